pipe_add_sub: RTL and testbench
===============================

Name: pipe_add_sub

Overview:
- Parametrised, pipelined add/subtract unit, the next generation of the team's combinational full adder.
- Operand width is split into STAGES equal carry-chain slices, with a register after each slice, so wide adds close timing at high clock rates.
- Adds a valid/ready handshake, a subtract mode with borrow-in, and a signed-overflow flag.
- Sits between operand-producing datapath logic and any downstream consumer that can apply backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages (slices); must be ≥ 1, ≤ WIDTH, and WIDTH % STAGES == 0, otherwise elaboration fails.
- Derived: SLICE = WIDTH/STAGES bits per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  unit accepts the beat this cycle
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- c_in  input  1  carry-in (sub=0) or borrow-in (sub=1)
- sub  input  1  0: add; 1: subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- c_out  output  1  carry-out; in subtract mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync deassert handled upstream): all stage valid bits clear; all data, carry and flag registers clear.
  - During reset: out_valid=0, sum=0, c_out=0, ovf=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards every in-flight beat. No stale beat appears after release.
- Arithmetic:
  - sub=0: {c_out,sum} = a + b + c_in.
  - sub=1: {c_out,sum} = a + ~b + ~c_in, i.e. a − b − c_in, where c_out=0 means a borrow occurred.
  - ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' is the effective (possibly inverted) b.
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k of A and B' with the carry registered by stage k-1. Stage 0 uses the effective carry-in.
  - Upper operand slices are carried forward in per-stage registers; completed lower result slices are delayed forward so all slices of a beat emerge together.
  - ovf is computed in the last stage.
- Latency: exactly STAGES cycles from accept (in_valid && in_ready at edge N) to out_valid=1 after edge N+STAGES−1, with no stall.
  - STAGES=1 degenerates to a single registered adder with latency 1.
- Flow control: global enable en = out_ready || !out_valid; in_ready = en.
  - When en=0, every stage register, including valid bits, holds. sum/c_out/ovf stay stable while out_valid && !out_ready.
  - When en=1, every stage advances. Stage-0 valid loads in_valid, so bubbles propagate as invalid slots and are not compressed.
  - Data registers of invalid slots may load anything; outputs are only meaningful when out_valid=1.
- Throughput: one beat per cycle while out_ready=1.
- Ordering: results leave in acceptance order; no loss or duplication under any out_ready pattern.
- in_valid=1 with in_ready=0: the beat is not taken, and the producer must hold it.
- Simultaneous output pop and input accept in the same cycle is legal and required for full throughput.

Test Plan:
- Reset: drive rst_n=0 with random inputs -> out_valid=0, sum=0, c_out=0, ovf=0. After release, in_ready=1.
- WIDTH=8, STAGES=4, out_ready=1:
  - a=FF, b=01, c_in=0, sub=0 -> exactly 4 cycles later sum=00, c_out=1, ovf=0.
  - a=7F, b=01 -> sum=80, c_out=0, ovf=1.
- Subtract:
  - a=05, b=07, c_in=0, sub=1 -> sum=FE, c_out=0, ovf=0.
  - a=10, b=03, c_in=1, sub=1 -> sum=0C, c_out=1, ovf=0.
  - a=80, b=01, sub=1 -> sum=7F, ovf=1.
- Backpressure: stream 10 random beats with out_ready toggling 1,0,1,0 and random in_valid gaps.
  - Results match the reference model, in order, no drops or duplicates.
  - in_ready=0 exactly when out_valid && !out_ready.
  - sum is stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight -> out_valid drops to 0 asynchronously. After release and 6 idle cycles, out_valid never rises.
- Configuration sweep: STAGES=1 and STAGES=WIDTH (WIDTH=8) -> latency 1 and 8 respectively, with identical results to the golden model on 1000 random operands.

Source files
------------

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: WIDTH-bit add/subtract split into STAGES carry-chain slices,
// one register per slice, with a valid/ready handshake and a signed overflow flag.
// A single global enable advances or freezes the whole pipe, so bubbles stay in
// place and a stalled result is held steady at the output.

// One carry-chain slice: {co,s} = a + b + ci.
module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int SLICE = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad
    $error("pipe_add_sub: WIDTH must be a non-zero multiple of STAGES");
  end

  // Subtract is a + ~b + ~borrow; everything downstream is a plain adder.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic             en;
  logic [STAGES:1]  vld_pipe;  // vld_pipe[k+1] is the valid bit of stage k

  assign b_eff     = b ^ {WIDTH{sub}};
  assign c_eff     = c_in ^ sub;
  assign out_valid = vld_pipe[STAGES];
  assign en        = out_ready || !out_valid;
  assign in_ready  = en;

  // Valid bits shift in lockstep with the data; empty slots travel as bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  vld_pipe <= '0;
    else if (en) vld_pipe <= (vld_pipe << 1) | STAGES'(in_valid);
  end

  if (STAGES == 1) begin : g_one
    logic [WIDTH-1:0] s_d, sum_q;
    logic             co_d, c_q, ovf_q;

    add_slice #(.W(WIDTH)) u_add (
      .a(a), .b(b_eff), .ci(c_eff), .s(s_d), .co(co_d)
    );

    // Single registered adder: capture the whole result when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        ovf_q <= 1'b0;
      end else if (en) begin
        sum_q <= s_d;
        c_q   <= co_d;
        ovf_q <= (a[WIDTH-1] == b_eff[WIDTH-1]) && (s_d[WIDTH-1] != a[WIDTH-1]);
      end
    end

    assign sum   = sum_q;
    assign c_out = c_q;
    assign ovf   = ovf_q;
  end else begin : g_multi
    // Storage is triangular and flattened so every bit is live:
    //  result region of stage k : (k+1)*SLICE bits at RO(k) = SLICE*k(k+1)/2
    //  operand region of stage k: WIDTH-k*SLICE bits (k>=1) at
    //                             OO(k) = SLICE*((k-1)*STAGES - (k-1)k/2)
    localparam int RES_BITS = SLICE * ((STAGES * (STAGES + 1)) / 2);
    localparam int OP_BITS  = SLICE * (((STAGES - 1) * STAGES) / 2);

    logic [RES_BITS-1:0] res_q, res_d;
    logic [OP_BITS-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [STAGES-1:0]   c_q, c_d;
    logic                ovf_q, ovf_d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int OW = WIDTH - k * SLICE;             // operand bits not yet consumed
      localparam int RO = SLICE * ((k * (k + 1)) / 2);   // this stage's result region

      logic [OW-1:0]    src_a, src_b;
      logic [SLICE-1:0] s;
      logic             ci, co;

      if (k == 0) begin : g_in
        assign src_a           = a;
        assign src_b           = b_eff;
        assign ci              = c_eff;
        assign res_d[SLICE-1:0] = s;
      end else begin : g_in
        localparam int OO  = SLICE * ((k - 1) * STAGES - ((k - 1) * k) / 2);
        localparam int PRO = SLICE * (((k - 1) * k) / 2);
        assign src_a = op_a_q[OO +: OW];
        assign src_b = op_b_q[OO +: OW];
        assign ci    = c_q[k-1];
        // Completed lower slices ride along so the whole word exits together.
        assign res_d[RO +: (k+1)*SLICE] = {s, res_q[PRO +: k*SLICE]};
      end

      add_slice #(.W(SLICE)) u_add (
        .a(src_a[SLICE-1:0]), .b(src_b[SLICE-1:0]), .ci(ci), .s(s), .co(co)
      );

      assign c_d[k] = co;

      if (k < STAGES - 1) begin : g_fwd
        localparam int NO = SLICE * (k * STAGES - (k * (k + 1)) / 2);
        assign op_a_d[NO +: OW-SLICE] = src_a[OW-1:SLICE];
        assign op_b_d[NO +: OW-SLICE] = src_b[OW-1:SLICE];
      end else begin : g_ovf
        // The top slice holds both sign bits, so overflow resolves here.
        assign ovf_d = (src_a[SLICE-1] == src_b[SLICE-1]) && (s[SLICE-1] != src_a[SLICE-1]);
      end
    end

    // Advance every stage together; hold everything while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_q  <= '0;
        op_a_q <= '0;
        op_b_q <= '0;
        c_q    <= '0;
        ovf_q  <= 1'b0;
      end else if (en) begin
        res_q  <= res_d;
        op_a_q <= op_a_d;
        op_b_q <= op_b_d;
        c_q    <= c_d;
        ovf_q  <= ovf_d;
      end
    end

    assign sum   = res_q[RES_BITS-1 -: WIDTH];
    assign c_out = c_q[STAGES-1];
    assign ovf   = ovf_q;
  end
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench: three 8-bit instances (4, 1 and 8 stages) share one operand stream.
// A per-instance scoreboard checks every popped result against an integer model
// of the add/subtract rules, plus flow-control, stall-hold and latency rules.
module tb_pipe_add_sub;
  localparam int W  = 8;
  localparam int ND = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   a, b;
  logic           c_in, sub;
  logic [ND-1:0]  in_ready_v, out_valid_v, out_ready_v, c_out_v, ovf_v;
  logic [W-1:0]   sum_v [ND];
  logic           or0;

  assign out_ready_v = {2'b11, or0};
  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : W);
    pipe_add_sub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[g]),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
      .sum(sum_v[g]), .c_out(c_out_v[g]), .ovf(ovf_v[g])
    );
  end

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, sb;
    bit           lit;
    logic [W-1:0] ls;
    logic         lc, lo;
    bit           lat;
    int           cyc;
  } beat_t;

  beat_t  q [ND][$];
  int     n_chk = 0;
  int     n_err = 0;
  int     cyc   = 0;
  bit     lat0;
  bit     lit_on;
  logic [W-1:0] lit_s;
  logic   lit_c, lit_o;

  function automatic int stages_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : W);
  endfunction

  // Returns {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic sb);
    int ux, uy, sx, sy, u, r;
    logic c, o;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!sb) begin
      u = ux + uy + int'(ci);
      r = sx + sy + int'(ci);
      c = (u > 255);
    end else begin
      u = ux - uy - int'(ci);
      r = sx - sy - int'(ci);
      c = (u >= 0);
    end
    o = (r > 127) || (r < -128);
    return {o, c, u[7:0]};
  endfunction

  task automatic check(input bit ok, input string nm, input int d, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard / rule checker, sampled on the falling edge.
  logic [W-1:0] hold_s [ND];
  logic [ND-1:0] hold_c, hold_o, stall_prev;
  initial begin
    beat_t e;
    logic [9:0] m, act;
    stall_prev = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        act = {ovf_v[d], c_out_v[d], sum_v[d]};
        if (!rst_n) begin
          check({out_valid_v[d], act} == 11'd0, "reset_outputs", d, {out_valid_v[d], act}, 0);
          q[d].delete();
          stall_prev[d] = 1'b0;
        end else begin
          check(in_ready_v[d] == !(out_valid_v[d] && !out_ready_v[d]), "in_ready_rule", d,
                in_ready_v[d], !(out_valid_v[d] && !out_ready_v[d]));
          if (stall_prev[d])
            check(out_valid_v[d] && act == {hold_o[d], hold_c[d], hold_s[d]}, "stall_hold", d,
                  {out_valid_v[d], act}, {1'b1, hold_o[d], hold_c[d], hold_s[d]});
          if (out_valid_v[d] && out_ready_v[d]) begin
            if (q[d].size() == 0) begin
              check(1'b0, "unexpected_beat", d, act, 0);
            end else begin
              e = q[d].pop_front();
              m = model(e.a, e.b, e.ci, e.sb);
              check(act == m, "result", d, act, m);
              if (e.lit) check(act == {e.lo, e.lc, e.ls}, "literal", d, act, {e.lo, e.lc, e.ls});
              if (e.lat) check(cyc - e.cyc == stages_of(d), "latency", d, cyc - e.cyc, stages_of(d));
            end
          end
          stall_prev[d] = out_valid_v[d] && !out_ready_v[d];
          hold_s[d] = sum_v[d];
          hold_c[d] = c_out_v[d];
          hold_o[d] = ovf_v[d];
          if (in_valid && in_ready_v[d]) begin
            e.a = a; e.b = b; e.ci = c_in; e.sb = sub;
            e.lit = lit_on; e.ls = lit_s; e.lc = lit_c; e.lo = lit_o;
            e.lat = (d != 0) || lat0;
            e.cyc = cyc;
            q[d].push_back(e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    a    = 8'($urandom);
    b    = 8'($urandom);
    c_in = 1'($urandom);
    sub  = 1'($urandom);
  endtask

  // Producer that holds an unaccepted beat; mode 0: ready=1, 1: toggle, 2: random.
  task automatic stream(input int nbeats, input int max_cyc, input int gap_pct, input int mode);
    int got = 0;
    int n = 0;
    bit pend = 0;
    while (got < nbeats && n < max_cyc) begin
      if (mode == 1)      or0 = ~or0;
      else if (mode == 2) or0 = 1'($urandom);
      else                or0 = 1'b1;
      if (!pend) begin
        if (int'($urandom_range(0, 99)) < gap_pct) in_valid = 1'b0;
        else begin
          in_valid = 1'b1;
          drive_rand();
          pend = 1;
        end
      end
      @(negedge clk);
      if (in_valid && in_ready_v[0]) begin
        got++;
        pend = 0;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    check(got == nbeats, "stream_accepted", 0, got, nbeats);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    or0 = 1'b1;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 64) begin
      tick();
      n++;
    end
    check((q[0].size() + q[1].size() + q[2].size()) == 0, "drain_empty", 0,
          q[0].size() + q[1].size() + q[2].size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] ta [5] = '{8'hFF, 8'h7F, 8'h05, 8'h10, 8'h80};
  logic [7:0] tb [5] = '{8'h01, 8'h01, 8'h07, 8'h03, 8'h01};
  logic       tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [9:0] tx [5] = '{10'h100, 10'h280, 10'h0FE, 10'h10C, 10'h37F};  // {ovf,c_out,sum}

  initial begin
    int cnt;
    logic [9:0] m;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    or0 = 1'b1; lat0 = 1'b0; lit_on = 1'b0; lit_s = '0; lit_c = 1'b0; lit_o = 1'b0;

    // Hand-computed values that pin the model.
    for (int i = 0; i < 5; i++) begin
      m = model(ta[i], tb[i], tc[i], ts[i]);
      check(m == tx[i], "model_pin", i, m, tx[i]);
    end

    // Reset with garbage on the inputs.
    repeat (3) begin
      in_valid = 1'($urandom);
      drive_rand();
      or0 = 1'($urandom);
      tick();
    end
    or0 = 1'b1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check(in_ready_v == 3'b111, "ready_after_reset", 0, in_ready_v, 3'b111);
    tick();

    // Directed vectors, back to back, no backpressure.
    lat0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; c_in = tc[i]; sub = ts[i];
      {lit_o, lit_c, lit_s} = tx[i];
      lit_on = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    lit_on = 1'b0;
    drain();
    lat0 = 1'b0;

    // Backpressure: out_ready toggles 1,0,1,0 with random gaps.
    or0 = 1'b0;
    stream(10, 200, 30, 1);
    drain();

    // 1000 random operands, continuous, fixed latency everywhere.
    lat0 = 1'b1;
    stream(1000, 1200, 0, 0);
    drain();
    lat0 = 1'b0;

    // Random backpressure and gaps.
    stream(200, 1500, 25, 2);
    drain();

    // Reset with beats in flight.
    in_valid = 1'b1;
    repeat (3) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    check(out_valid_v[1] == 1'b1, "valid_before_reset", 1, out_valid_v[1], 1);
    #2 rst_n = 1'b0;
    #1 check(out_valid_v == 3'b000, "async_reset_valid", 0, out_valid_v, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (|out_valid_v) cnt++;
      tick();
    end
    check(cnt == 0, "stale_after_reset", 0, cnt, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
